// File: rtl/pipelined_tree_multiplier.sv
// Pipelined N x N multiplier, signed or unsigned per beat.
// Stages: S1 partial products, S2 carry-save tree to a sum/carry pair,
// S3 final carry-propagate add, S4 optional output register.
// Every stage carries its own valid and mode bit. The pipeline advances
// as a single unit whenever the output slot is empty or being consumed.
module pipelined_tree_multiplier #(
    parameter int unsigned N       = 8,
    parameter bit          OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic             busy
);

    localparam int unsigned W    = 2 * N;
    localparam int unsigned ROWS = N + 1;

    logic adv;
    logic accept;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // ------------------------------------------------------------------
    // S1: partial-product generation
    // ------------------------------------------------------------------
    logic [W-1:0] a_ext;
    logic [W-1:0] pp_d [ROWS];

    logic         s1_valid_q;
    logic         s1_signed_q;
    logic [W-1:0] s1_pp_q [ROWS];

    // Build one row per multiplier bit. In signed mode the top row carries
    // negative weight, so it is entered as its one's complement and the
    // missing +1 goes into the extra correction row. Non-accepted cycles
    // carry all-zero rows so bubbles hold a zero product.
    always_comb begin
        a_ext = is_signed ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
        for (int unsigned i = 0; i < ROWS; i++) begin
            pp_d[i] = '0;
        end
        if (accept) begin
            for (int unsigned i = 0; i < N - 1; i++) begin
                if (b[i]) begin
                    pp_d[i] = a_ext << i;
                end
            end
            if (b[N-1]) begin
                if (is_signed) begin
                    pp_d[N-1] = ~(a_ext << (N - 1));
                    pp_d[N]   = W'(1);
                end else begin
                    pp_d[N-1] = a_ext << (N - 1);
                end
            end
        end
    end

    // S1 register: capture the beat's partial products and mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_signed_q <= 1'b0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                s1_pp_q[i] <= '0;
            end
        end else if (adv) begin
            s1_valid_q  <= accept;
            s1_signed_q <= accept ? is_signed : 1'b0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                s1_pp_q[i] <= pp_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: carry-save (3:2) tree reduction
    // ------------------------------------------------------------------
    logic [W-1:0] red_rows [ROWS];
    logic [W-1:0] red_next [ROWS];
    int unsigned  red_cnt;
    int unsigned  red_groups;
    int unsigned  red_rem;
    logic [W-1:0] csa_x;
    logic [W-1:0] csa_y;
    logic [W-1:0] csa_z;
    logic [W-1:0] sum_d;
    logic [W-1:0] carry_d;

    logic         s2_valid_q;
    logic         s2_signed_q;
    logic [W-1:0] s2_sum_q;
    logic [W-1:0] s2_carry_q;

    // Each level compresses every full group of three rows into two and
    // passes leftover rows through, until a sum/carry pair remains.
    // All arithmetic is modulo 2^W, so carries out of the top bit drop.
    always_comb begin
        for (int unsigned i = 0; i < ROWS; i++) begin
            red_rows[i] = s1_pp_q[i];
            red_next[i] = '0;
        end
        red_cnt    = ROWS;
        red_groups = 0;
        red_rem    = 0;
        csa_x      = '0;
        csa_y      = '0;
        csa_z      = '0;
        for (int unsigned lvl = 0; lvl < ROWS; lvl++) begin
            if (red_cnt > 2) begin
                red_groups = red_cnt / 3;
                red_rem    = red_cnt % 3;
                for (int unsigned i = 0; i < ROWS; i++) begin
                    red_next[i] = '0;
                end
                for (int unsigned g = 0; g < ROWS / 3; g++) begin
                    if (g < red_groups) begin
                        csa_x = red_rows[3*g];
                        csa_y = red_rows[3*g+1];
                        csa_z = red_rows[3*g+2];
                        red_next[2*g]   = csa_x ^ csa_y ^ csa_z;
                        red_next[2*g+1] = ((csa_x & csa_y) | (csa_x & csa_z) |
                                           (csa_y & csa_z)) << 1;
                    end
                end
                for (int unsigned r = 0; r < 2; r++) begin
                    if (r < red_rem) begin
                        red_next[2*red_groups+r] = red_rows[3*red_groups+r];
                    end
                end
                for (int unsigned i = 0; i < ROWS; i++) begin
                    red_rows[i] = red_next[i];
                end
                red_cnt = 2 * red_groups + red_rem;
            end
        end
        sum_d   = red_rows[0];
        carry_d = red_rows[1];
    end

    // S2 register: hold the reduced sum/carry pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_signed_q <= 1'b0;
            s2_sum_q    <= '0;
            s2_carry_q  <= '0;
        end else if (adv) begin
            s2_valid_q  <= s1_valid_q;
            s2_signed_q <= s1_signed_q;
            s2_sum_q    <= sum_d;
            s2_carry_q  <= carry_d;
        end
    end

    // ------------------------------------------------------------------
    // S3: final carry-propagate add
    // ------------------------------------------------------------------
    logic         s3_valid_q;
    logic         s3_signed_q;
    logic [W-1:0] s3_prod_q;

    // S3 register: resolve the sum/carry pair into the product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_valid_q  <= 1'b0;
            s3_signed_q <= 1'b0;
            s3_prod_q   <= '0;
        end else if (adv) begin
            s3_valid_q  <= s2_valid_q;
            s3_signed_q <= s2_signed_q;
            s3_prod_q   <= s2_sum_q + s2_carry_q;
        end
    end

    // ------------------------------------------------------------------
    // S4: optional output register
    // ------------------------------------------------------------------
    logic unused_mode;

    if (OUT_REG) begin : g_out_reg
        logic         s4_valid_q;
        logic         s4_signed_q;
        logic [W-1:0] s4_prod_q;

        // S4 register: extra retiming stage in front of the output.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s4_valid_q  <= 1'b0;
                s4_signed_q <= 1'b0;
                s4_prod_q   <= '0;
            end else if (adv) begin
                s4_valid_q  <= s3_valid_q;
                s4_signed_q <= s3_signed_q;
                s4_prod_q   <= s3_prod_q;
            end
        end

        assign out_valid   = s4_valid_q;
        assign product     = s4_prod_q;
        assign busy        = s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q;
        assign unused_mode = s4_signed_q;
    end else begin : g_no_out_reg
        assign out_valid   = s3_valid_q;
        assign product     = s3_prod_q;
        assign busy        = s1_valid_q | s2_valid_q | s3_valid_q;
        assign unused_mode = s3_signed_q;
    end

endmodule

// File: doc/pipelined_tree_multiplier.md
PIPELINED_TREE_MULTIPLIER -- requirements
Module: pipelined_tree_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 8, which sets the operand width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter OUT_REG, default 1, where 1 adds an output register stage and 0 omits it.
REQ-003 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  Synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  Operand beat valid.
REQ-006 in_ready  output  1  Block accepts a beat this cycle.
REQ-007 a  input  N  Multiplicand.
REQ-008 b  input  N  Multiplier.
REQ-009 is_signed  input  1  Operand mode: 1 = two's-complement, 0 = unsigned; it is captured with the beat.
REQ-010 out_valid  output  1  Product valid.
REQ-011 out_ready  input  1  Downstream accepts the product.
REQ-012 product  output  2N  Full-width product.
REQ-013 busy  output  1  High while any pipeline stage holds a valid beat.

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a product SHALL be delivered on an edge where out_valid and out_ready are both 1.
REQ-015 The pipeline SHALL consist of these stages:
- S1: operand capture and partial-product generation.
- S2: carry-save tree reduction to a sum/carry pair, 2N bits each.
- S3: final carry-propagate add.
- S4: output register, present only when OUT_REG=1.
REQ-016 Latency from acceptance to out_valid SHALL be 3 cycles when OUT_REG=0 and 4 cycles when OUT_REG=1.
REQ-017 With out_ready held at 1, the block SHALL sustain a throughput of one beat per cycle.
REQ-018 Unsigned mode SHALL produce product = a*b exactly, in 2N bits.
REQ-019 Signed mode SHALL produce product = a*b exactly as a 2N-bit two's-complement value, including the case a = b = -2^(N-1).
REQ-020 Each stage SHALL carry its own valid bit and its own copy of is_signed, so that beats of mixed mode can be in flight together.
REQ-021 The pipeline advance enable SHALL be adv = !out_valid || out_ready.
REQ-022 All stages SHALL advance together only when adv=1, and every stage register SHALL hold its value when adv=0.
REQ-023 in_ready SHALL equal adv, combinationally.
REQ-024 While stalled, product and out_valid SHALL remain stable until the handshake completes.
REQ-025 Bubbles SHALL propagate as valid=0 beats; gaps in the input SHALL NOT be compressed.
REQ-026 in_valid=1 while in_ready=0 SHALL NOT capture the beat, and a, b and is_signed SHALL be ignored in that cycle.
REQ-027 When an accept and a delivery occur on the same edge, both SHALL take effect, with no loss and no duplication.
REQ-028 busy SHALL be the OR of all stage valid bits.
REQ-029 Beats SHALL emerge in acceptance order, and no beat SHALL be lost or duplicated under any pattern of out_ready.
REQ-030 product SHALL be all zeros whenever out_valid=0 after reset, until the first valid beat arrives.

Reset
REQ-031 When rst_n=0 at a rising edge, every stage valid bit SHALL clear to 0 and every data register SHALL clear to 0.
REQ-032 During reset, outputs SHALL be: out_valid=0, busy=0, product=0.
REQ-033 During reset, in_ready SHALL be 1, following adv.
REQ-034 A reset asserted mid-operation SHALL discard all in-flight beats, and no stale product SHALL appear afterwards.
REQ-035 Any beat presented in the same cycle that rst_n=0 SHALL NOT be accepted.
REQ-036 The first accept after reset SHALL be possible on the first edge with rst_n=1.

Verification (N=8, OUT_REG=1)
REQ-037 Unsigned maximum: a=0xFF, b=0xFF, is_signed=0, out_ready=1 -> product=0xFE01 with out_valid=1 exactly 4 cycles after acceptance.
REQ-038 Signed corners: (-128)*(-128) gives 0x4000, (-1)*(1) gives 0xFFFF, and 127*(-128) gives 0xC080. All three are issued back-to-back and SHALL emerge on consecutive cycles in order.
REQ-039 Mixed mode in flight: a=0xFF, b=0x02 issued first with is_signed=0, then again with is_signed=1 -> products 0x01FE and then 0xFFFE.
REQ-040 Backpressure:
- Stimulus: issue 5 beats (1*1, 2*2, 3*3, 4*4, 5*5) with out_ready=0 for 6 cycles, then out_ready=1.
- Response: in_ready drops once the pipeline fills, product holds 0x0001 while stalled, and 0x0001, 0x0004, 0x0009, 0x0010, 0x0019 are then delivered in order with none lost.
REQ-041 Reset mid-flight: issue 3 beats, assert rst_n=0 for 1 cycle at cycle 2 -> out_valid stays 0 afterwards, busy=0, and a new beat 6*7 returns 0x002A after 4 cycles.
REQ-042 Random run: 10,000 random a, b and is_signed values with random in_valid/out_ready duty -> every product matches the reference model, in order, and the count of outputs equals the count of accepts.
